// File: rtl/aggregator_scheduler.sv
// aggregator_scheduler: round-robin frame scheduler between two compression
// engines and the single aggregator input.
//
// Ports:
//   clk, reset (async, active-low), enable (gates new grants)
//   DATA_IN1/2, valid_1/2 in; ready_1/2 out : engine streams
//   DATA_OUT, valid out; ready in           : aggregator stream
//   sof, eof                                : frame markers, qualified by valid
//   grant                                   : registered one-hot grant
//   timeout_err                             : one-cycle watchdog pulse
// Optional feature: define SCHED_TIMEOUT_EN to build the stall watchdog.
module aggregator_scheduler #(
   parameter int DATA_WIDTH     = 255,
   parameter int LENGTH_WIDTH   = 31,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH:0]   DATA_IN1,
   input  logic [DATA_WIDTH:0]   DATA_IN2,
   input  logic                  valid_1,
   input  logic                  valid_2,
   output logic                  ready_1,
   output logic                  ready_2,
   output logic [DATA_WIDTH:0]   DATA_OUT,
   output logic                  valid,
   input  logic                  ready,
   output logic                  sof,
   output logic                  eof,
   output logic [1:0]            grant,
   output logic                  timeout_err
);

   localparam int BLW = LENGTH_WIDTH - 3;
   localparam int CW  = LENGTH_WIDTH + 2;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit in 16 bits and be nonzero");
   end

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      BODY
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_grant;
   logic [1:0]       w_grant_nxt;
   // r_ptr = 1 means engine 2 was granted last, so engine 1 wins a tie
   logic             r_ptr;
   logic             w_ptr_nxt;
   logic [BLW-1:0]   r_beats_left;
   logic [BLW-1:0]   w_bl_nxt;
   logic [LENGTH_WIDTH:0] w_len;
   logic [CW-1:0]    w_beats;
   logic [CW-1:0]    w_beats_m1;
   logic             w_hs;
   logic             w_last;

`ifdef SCHED_TIMEOUT_EN
   localparam logic [15:0] LP_TMO_M1 = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]      r_wd;
   logic [15:0]      w_wd_nxt;
   logic             r_tmo;
   logic             w_tmo_nxt;
`endif

   // zero-latency forwarding from the registered grant
   always_comb begin
      DATA_OUT = '0;
      valid    = 1'b0;
      unique case (1'b1)
         r_grant[0]: begin
            DATA_OUT = DATA_IN1;
            valid    = valid_1;
         end
         r_grant[1]: begin
            DATA_OUT = DATA_IN2;
            valid    = valid_2;
         end
         default: ;
      endcase
   end

   assign ready_1 = r_grant[0] & ready;
   assign ready_2 = r_grant[1] & ready;
   assign grant   = r_grant;

   // header length decode; wide enough that L = all-ones cannot wrap
   assign w_len      = DATA_OUT[DATA_WIDTH -: LENGTH_WIDTH+1];
   assign w_beats    = (CW'(w_len) + CW'(31)) >> 5;
   assign w_beats_m1 = (w_beats == '0) ? '0 : w_beats - CW'(1);

   assign w_hs   = valid & ready;
   assign w_last = (r_state == HEADER) ? (w_beats_m1 == '0)
                 : (r_state == BODY) && (r_beats_left == BLW'(1));

   assign sof = valid & (r_state == HEADER);
   assign eof = valid & w_last;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      w_bl_nxt    = r_beats_left;
`ifdef SCHED_TIMEOUT_EN
      w_wd_nxt    = r_wd;
      w_tmo_nxt   = 1'b0;
`endif
      unique case (r_state)
         IDLE: begin
            if (enable && (valid_1 || valid_2)) begin
               w_state_nxt = HEADER;
               w_grant_nxt = (valid_1 && (!valid_2 || r_ptr))
                           ? 2'b01 : 2'b10;
            end
         end
         HEADER: begin
            if (w_hs) begin
               w_bl_nxt    = w_beats_m1[BLW-1:0];
               w_state_nxt = w_last ? IDLE : BODY;
            end
         end
         BODY: begin
            if (w_hs) begin
               w_bl_nxt = r_beats_left - BLW'(1);
               if (w_last) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (r_state != IDLE && w_hs && w_last) begin
         w_grant_nxt = 2'b00;
         w_ptr_nxt   = r_grant[1];
      end

`ifdef SCHED_TIMEOUT_EN
      // only cycles with the granted engine silent count toward a stall
      if (r_state == IDLE || w_hs) begin
         w_wd_nxt = '0;
      end else if (!valid) begin
         if (r_wd == LP_TMO_M1) begin
            w_wd_nxt    = '0;
            w_tmo_nxt   = 1'b1;
            w_state_nxt = IDLE;
            w_grant_nxt = 2'b00;
            w_ptr_nxt   = r_grant[1];
         end else begin
            w_wd_nxt = r_wd + 16'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_grant      <= 2'b00;
         r_ptr        <= 1'b1;
         r_beats_left <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_ptr        <= w_ptr_nxt;
         r_beats_left <= w_bl_nxt;
      end
   end

`ifdef SCHED_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wd  <= '0;
         r_tmo <= 1'b0;
      end else begin
         r_wd  <= w_wd_nxt;
         r_tmo <= w_tmo_nxt;
      end
   end

   assign timeout_err = r_tmo;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_aggregator_scheduler.sv
// tb_aggregator_scheduler: scoreboard bench for aggregator_scheduler.
// Engine beat queues feed the DUT; expected beats are compared on handshake.
module tb_aggregator_scheduler;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b1;
   logic [255:0] DATA_IN1 = '0;
   logic [255:0] DATA_IN2 = '0;
   logic         valid_1 = 1'b0;
   logic         valid_2 = 1'b0;
   logic         ready_1;
   logic         ready_2;
   logic [255:0] DATA_OUT;
   logic         valid;
   logic         ready = 1'b1;
   logic         sof;
   logic         eof;
   logic [1:0]   grant;
   logic         timeout_err;

   aggregator_scheduler #(
      .DATA_WIDTH(255),
      .LENGTH_WIDTH(31),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .DATA_IN1(DATA_IN1),
      .DATA_IN2(DATA_IN2),
      .valid_1(valid_1),
      .valid_2(valid_2),
      .ready_1(ready_1),
      .ready_2(ready_2),
      .DATA_OUT(DATA_OUT),
      .valid(valid),
      .ready(ready),
      .sof(sof),
      .eof(eof),
      .grant(grant),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] d;
      logic         s;
      logic         e;
      logic [1:0]   g;
   } exp_t;

   logic [255:0] q1[$];
   logic [255:0] q2[$];
   exp_t         sb[$];
   int           n_chk = 0;
   int           n_fail = 0;
   logic         hs1 = 1'b0;
   logic         hs2 = 1'b0;

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // queue nsend beats of an nb-beat frame on engine eng
   task automatic push_frame(input int eng, input logic [31:0] len,
                             input int nb, input int nsend);
      exp_t x;
      for (int i = 0; i < nsend; i++) begin
         x.d = rnd256();
         if (i == 0) x.d[255:224] = len;
         x.s = (i == 0);
         x.e = (i == nb - 1);
         x.g = (eng == 1) ? 2'b01 : 2'b10;
         if (eng == 1) q1.push_back(x.d);
         else          q2.push_back(x.d);
         sb.push_back(x);
      end
   endtask

   // monitor: handshake will occur on the coming rising edge
   always @(negedge clk) begin
      exp_t e;
      hs1 = valid_1 && ready_1;
      hs2 = valid_2 && ready_2;
      if (reset && valid && ready) begin
         if (sb.size() == 0) begin
            chk("sb_extra_beat", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("data", DATA_OUT, e.d);
            chk("sof", sof, e.s);
            chk("eof", eof, e.e);
            chk("grant", grant, e.g);
            chk("rdy_other", (e.g == 2'b01) ? ready_2 : ready_1, 0);
         end
      end
   end

   // engine drivers
   always @(posedge clk) begin
      #1;
      if (hs1 && reset && q1.size() > 0) void'(q1.pop_front());
      if (hs2 && reset && q2.size() > 0) void'(q2.pop_front());
      valid_1  = (q1.size() > 0);
      DATA_IN1 = valid_1 ? q1[0] : '0;
      valid_2  = (q2.size() > 0);
      DATA_IN2 = valid_2 ? q2[0] : '0;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input int left, input int budget);
      int n = 0;
      while (sb.size() > left && n < budget) begin
         step();
         n++;
      end
      chk("drain", sb.size(), left);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      q1.delete();
      q2.delete();
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   logic [1:0] seq [5];
   logic [255:0] hold_d;
   int idx;
   int npulse;

   initial begin
      #200000;
      $display("FAIL tb_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      // reset values
      repeat (2) @(posedge clk);
      #2;
      chk("rst_grant", grant, 2'b00);
      chk("rst_valid", valid, 0);
      chk("rst_ready1", ready_1, 0);
      chk("rst_ready2", ready_2, 0);
      chk("rst_sof", sof, 0);
      chk("rst_eof", eof, 0);
      chk("rst_data", DATA_OUT, 0);
      chk("rst_tmo", timeout_err, 0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // single engine, L=100 -> 4 beats
      push_frame(1, 32'd100, 4, 4);
      step();
      chk("req_cycle_grant", grant, 2'b00);
      step();
      chk("grant_n1", grant, 2'b01);
      drain(0, 50);
      chk("grant_after", grant, 2'b00);
      chk("valid_after", valid, 0);

      // both engines, L=32 each, twice
      do_reset();
      seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b00;
      seq[3] = 2'b10; seq[4] = 2'b00;
      for (int r = 0; r < 2; r++) begin
         push_frame(1, 32'd32, 1, 1);
         push_frame(2, 32'd32, 1, 1);
         for (int t = 0; t < 5; t++) begin
            step();
            chk($sformatf("rr%0d_t%0d", r, t), grant, seq[t]);
         end
         drain(0, 10);
      end

      // length boundaries
      push_frame(2, 32'd0, 1, 1);
      drain(0, 20);
      push_frame(2, 32'd33, 2, 2);
      drain(0, 20);

      // backpressure, L=96 -> 3 beats
      push_frame(1, 32'd96, 3, 3);
      idx = 0;
      while (sb.size() > 2 && idx < 20) begin
         step();
         idx++;
      end
      chk("bp_hdr_done", sb.size(), 2);
      ready = 1'b0;
      hold_d = sb[0].d;
      for (int t = 0; t < 3; t++) begin
         step();
         chk("bp_data", DATA_OUT, hold_d);
         chk("bp_valid", valid, 1);
         chk("bp_ready1", ready_1, 0);
         chk("bp_ready2", ready_2, 0);
      end
      ready = 1'b1;
      drain(0, 20);

      // enable dropped during a frame
      push_frame(1, 32'd100, 4, 4);
      idx = 0;
      while (grant != 2'b01 && idx < 10) begin
         step();
         idx++;
      end
      chk("en_grant", grant, 2'b01);
      enable = 1'b0;
      push_frame(2, 32'd32, 1, 1);
      drain(1, 30);
      for (int t = 0; t < 5; t++) begin
         step();
         chk("en_hold", grant, 2'b00);
      end
      enable = 1'b1;
      drain(0, 20);

      // L = 0xFFFFFFFF, then reset mid-frame
      push_frame(1, 32'hFFFF_FFFF, 134217728, 3);
      drain(0, 30);
      chk("bl_max", dut.r_beats_left, 28'h7FF_FFFD);
      chk("mid_grant", grant, 2'b01);
      reset = 1'b0;
      q1.delete();
      #1;
      chk("mid_rst_grant", grant, 2'b00);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_eof", eof, 0);
      @(negedge clk);
      reset = 1'b1;
      step();

`ifdef SCHED_TIMEOUT_EN
      // watchdog: header only, then engine goes silent
      push_frame(1, 32'd100, 4, 1);
      drain(0, 20);
      idx = 0;
      npulse = 0;
      for (int t = 1; t <= 16; t++) begin
         step();
         if (timeout_err) begin
            npulse++;
            if (idx == 0) idx = t;
            chk("tmo_grant", grant, 2'b00);
         end
      end
      chk("tmo_pulses", npulse, 1);
      chk("tmo_at", idx, 8);
      push_frame(2, 32'd32, 1, 1);
      push_frame(1, 32'd32, 1, 1);
      drain(0, 20);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aggregator_scheduler.md
# aggregator_scheduler

Round-robin scheduler that shares the single input of the downstream aggregator between two compression engines. It grants one engine at a time and forwards that engine's valid/ready stream unmodified for one complete frame. The frame length is decoded from the header beat, and the grant moves only on a frame boundary. It sits between the engine outputs and the aggregator `DATA_IN` / `valid` / `ready` port.

## Interface
Parameters:
- `DATA_WIDTH`, 255 — MSB index of a data beat (beat is `DATA_WIDTH+1` bits, 256 by default).
- `LENGTH_WIDTH`, 31 — MSB index of the frame length field.
- `TIMEOUT_CYCLES`, 1024 — watchdog limit, 16-bit; only used with `SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  — clock; one clock domain; all logic on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `enable`  in  1  — high allows new grants. Low blocks new grants; the current frame still completes.
- `DATA_IN1`, `DATA_IN2`  in  `DATA_WIDTH+1`  — engine beats.
- `valid_1`, `valid_2`  in  1  — engine beat valid.
- `ready_1`, `ready_2`  out  1  — engine beat accept.
- `DATA_OUT`  out  `DATA_WIDTH+1`  — beat to the aggregator.
- `valid`  out  1  — beat valid to the aggregator.
- `ready`  in  1  — aggregator accept.
- `sof`, `eof`  out  1  — first / last beat of the frame; qualified by `valid`.
- `grant`  out  2  — one-hot registered grant: bit0 = engine 1, bit1 = engine 2.
- `timeout_err`  out  1  — one-cycle pulse. Driven 0 when the macro is not defined.

## Operation
- Handshake: a beat transfers when `valid && ready` on a rising edge.
- States: `IDLE`, `HEADER`, `BODY`.
- **IDLE**
  - `grant` = 0; `valid` = 0; `ready_1` = `ready_2` = 0.
  - If `enable` is high and any `valid_k` is high, register the grant and go to `HEADER`.
  - Round-robin: with one requester, grant it. With both, grant the engine not granted last. Pointer after reset = engine 2, so engine 1 wins first.
- **HEADER / BODY forwarding** (combinational from the registered grant):
  - `DATA_OUT` = granted `DATA_INk`; `valid` = granted `valid_k`; granted `ready_k` = `ready`.
  - Non-granted `ready` is held 0.
  - When no engine is granted, `DATA_OUT` = 0.
- **HEADER**
  - `sof` = 1.
  - L = `DATA_OUT[DATA_WIDTH:DATA_WIDTH-LENGTH_WIDTH]` = frame bytes including the 4-byte header.
  - beats = `(L+31)>>5`, computed in `LENGTH_WIDTH+2` bits (no overflow at L = 0xFFFFFFFF). L = 0 is treated as 1 beat.
  - On handshake: `beats_left` = beats−1.
    - If 0: `eof` = 1 on this beat; go to `IDLE`; update the pointer.
    - Else: go to `BODY`.
- **BODY**
  - On handshake: decrement `beats_left`.
  - `eof` = 1 when `beats_left` == 1; after that handshake go to `IDLE` and update the pointer.
- `enable` is sampled only in `IDLE`.
- `beats_left` width: `LENGTH_WIDTH-3` bits.

## Timing
- Reset values: state `IDLE`, `grant` 0, pointer = engine 2, `beats_left` 0, watchdog 0, `timeout_err` 0. Hence `valid`, `ready_1`, `ready_2`, `sof`, `eof` are 0 and `DATA_OUT` is 0.
- Arbitration latency: a request in `IDLE` at cycle n gives `grant` valid at n+1; the first beat can transfer at n+1.
- Forwarding: zero-latency combinational path; no data registers.
- Frame gap: exactly one `IDLE` cycle between consecutive frames.
- Backpressure: `ready` low holds the engine stalled; no beat is lost or duplicated.
- Reset mid-frame: immediate return to `IDLE` with `grant` 0. The partial frame is abandoned and no `eof` is issued.

## Configuration
- `SCHED_TIMEOUT_EN` defined: watchdog active in `HEADER` and `BODY`.
  - It counts cycles where granted `valid_k` = 0; a handshake clears it.
  - Cycles with `valid` high and `ready` low do not count.
  - On reaching `TIMEOUT_CYCLES`: `timeout_err` pulses 1 cycle, `grant` drops, state goes to `IDLE`, the pointer advances, and the frame is truncated (no `eof`).
- `SCHED_TIMEOUT_EN` undefined: no watchdog logic; `timeout_err` is tied 0; the grant is held indefinitely.

## Test plan
- Engine 1 sends L=100 → grant=01 one cycle after request; 4 beats; `sof` on beat 1, `eof` on beat 4; `grant`=00 the next cycle.
- Both engines valid at the same time after reset, each with L=32 → engine 1 frame (1 beat), one `IDLE` cycle, then engine 2 frame. Repeated frames alternate.
- L=0 → 1 beat with `sof` and `eof` both high. L=33 → 2 beats. L=0xFFFFFFFF → `beats_left` loads 0x7FFFFFF without overflow.
- Engine 1 with L=96, `ready` low 3 cycles after beat 1 → `DATA_OUT` holds, `ready_1`=0, `ready_2`=0, all 3 beats delivered in order.
- `enable` dropped during a 4-beat frame → frame completes with `eof`; no new grant while `enable`=0.
- Reset asserted mid-frame → `grant` 0 at once. With `SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: engine stalls `valid` 8 cycles → `timeout_err` 1-cycle pulse, `grant`=00, next frame granted to the other engine.
